// File: rtl/uw_channel_sequencer_pkg.sv
// Shared types and constants for the Unet_Wrapper channel sequencer.
// Contents:
//   seq_state_e        - controller state encoding
//   MODE_SEQ/MODE_CONC - values of the MODE input
//   cnt_width()        - width of the shared GAP/PULSE/WAIT counter
package uw_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGap,
        StPulse,
        StWait,
        StFinish
    } seq_state_e;

    localparam logic MODE_SEQ  = 1'b0;
    localparam logic MODE_CONC = 1'b1;

    // The counter only ever holds 0..limit-1, so $clog2(limit) bits suffice.
    function automatic int unsigned cnt_width(input int unsigned gap_cycles,
                                              input int unsigned pulse_len,
                                              input int unsigned timeout_cycles);
        int unsigned m;
        m = gap_cycles;
        if (pulse_len > m) m = pulse_len;
        if (timeout_cycles > m) m = timeout_cycles;
        return (m < 2) ? 32'd1 : 32'($clog2(m));
    endfunction

endpackage

// File: rtl/uw_channel_sequencer_if.sv
// Launch/collect bundle between the sequencer and the Unet_Wrapper channels.
// master: the sequencer (drives INIT_AXI_TXN, BUSY, DONE and result masks).
// slave : the surrounding system (drives START/MODE/CH_ENABLE, TXN_DONE/ERROR).
interface uw_channel_sequencer_if #(
    parameter int unsigned NUM_CH = 8
);
    logic              START;
    logic              MODE;
    logic [NUM_CH-1:0] CH_ENABLE;
    logic [NUM_CH-1:0] INIT_AXI_TXN;
    logic [NUM_CH-1:0] TXN_DONE;
    logic [NUM_CH-1:0] ERROR;
    logic              BUSY;
    logic              DONE;
    logic [NUM_CH-1:0] PASS_MASK;
    logic [NUM_CH-1:0] FAIL_MASK;
    logic [NUM_CH-1:0] TIMEOUT_MASK;

    modport master (
        input  START, MODE, CH_ENABLE, TXN_DONE, ERROR,
        output INIT_AXI_TXN, BUSY, DONE, PASS_MASK, FAIL_MASK, TIMEOUT_MASK
    );

    modport slave (
        output START, MODE, CH_ENABLE, TXN_DONE, ERROR,
        input  INIT_AXI_TXN, BUSY, DONE, PASS_MASK, FAIL_MASK, TIMEOUT_MASK
    );
endinterface

// File: rtl/uw_seq_ch_tracker.sv
// Per-channel completion tracker.
// Ports:
//   clk_i, rst_ni  - clock, synchronous active-low reset
//   clear_i        - start of a run: forget previous completion
//   arm_i          - channel is being waited on (PULSE/WAIT, selected channel)
//   force_i        - mark complete without a done edge (watchdog)
//   txn_done_i     - TXN_DONE level from the wrapper
//   error_i        - ERROR level from the wrapper
//   hit_o          - completion edge recorded this cycle
//   err_o          - ERROR sampled on that completion edge
//   complete_o     - sticky: channel finished (edge or forced) this run
module uw_seq_ch_tracker (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic arm_i,
    input  logic force_i,
    input  logic txn_done_i,
    input  logic error_i,
    output logic hit_o,
    output logic err_o,
    output logic complete_o
);
    logic done_q;
    logic complete_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            done_q     <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            done_q <= txn_done_i;
            if (clear_i) begin
                complete_q <= 1'b0;
            end else if (hit_o || force_i) begin
                complete_q <= 1'b1;
            end
        end
    end

    // A level already high when arming never produces an edge; only a fresh 0->1 counts.
    assign hit_o      = arm_i & ~complete_q & txn_done_i & ~done_q;
    assign err_o      = hit_o & error_i;
    assign complete_o = complete_q;
endmodule

// File: rtl/uw_channel_sequencer.sv
// Launch-and-collect controller for the Unet_Wrapper AXI master channels.
// Pulses INIT_AXI_TXN per channel (sequentially or all at once), waits for a
// fresh TXN_DONE rising edge and records ERROR into PASS/FAIL masks.
// Ports:
//   ACLK, ARESETN - clock, synchronous active-low reset
//   bus (master)  - START/MODE/CH_ENABLE in, INIT_AXI_TXN out, TXN_DONE/ERROR in,
//                   BUSY/DONE and PASS/FAIL/TIMEOUT_MASK out (all registered)
// Build option: define UW_SEQ_TIMEOUT_EN to add the WAIT watchdog and TIMEOUT_MASK.
module uw_channel_sequencer
    import uw_seq_pkg::*;
#(
    parameter int unsigned NUM_CH         = 8,
    parameter int unsigned GAP_CYCLES     = 20,
    parameter int unsigned PULSE_LEN      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    uw_channel_sequencer_if.master  bus
);
    localparam int unsigned CW = cnt_width(GAP_CYCLES, PULSE_LEN, TIMEOUT_CYCLES);
    localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);
    // With no gap the launch goes straight into PULSE.
    localparam seq_state_e LAUNCH_ST = (GAP_CYCLES == 0) ? StPulse : StGap;

    seq_state_e        state_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     cur_q;
    logic              mode_q;
    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] init_q;
    logic [NUM_CH-1:0] pass_q;
    logic [NUM_CH-1:0] fail_q;
    logic              busy_q;
    logic              done_q;

    logic [NUM_CH-1:0] arm, hit, err_hit, complete, force_done;
    logic              active, all_done, cur_done, tmo_fire, start_acc;
    logic [IW:0]       first_ch, next_ch;

    // Lowest enabled index >= from; MSB flags that one was found.
    function automatic logic [IW:0] find_next(input logic [NUM_CH-1:0] en, input int from);
        logic [IW:0] r;
        r = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (en[i] && i >= from) r = {1'b1, IW'(i)};
        end
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] onehot(input logic [IW-1:0] idx);
        logic [NUM_CH-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    assign active    = (state_q == StPulse) || (state_q == StWait);
    assign start_acc = (state_q == StIdle) && bus.START;
    assign first_ch  = find_next(bus.CH_ENABLE, 0);
    assign next_ch   = find_next(en_q, int'(cur_q) + 1);
    assign all_done  = &(complete | hit | ~en_q);
    assign cur_done  = complete[cur_q] | hit[cur_q];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign arm[i] = active & en_q[i] & ((mode_q == MODE_CONC) | (cur_q == IW'(i)));

        uw_seq_ch_tracker u_tracker (
            .clk_i      (ACLK),
            .rst_ni     (ARESETN),
            .clear_i    (start_acc),
            .arm_i      (arm[i]),
            .force_i    (force_done[i]),
            .txn_done_i (bus.TXN_DONE[i]),
            .error_i    (bus.ERROR[i]),
            .hit_o      (hit[i]),
            .err_o      (err_hit[i]),
            .complete_o (complete[i])
        );
    end

`ifdef UW_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [NUM_CH-1:0] tmo_q;

    // Sequential: arm covers only the current channel, so the counter is per channel.
    assign tmo_fire   = (state_q == StWait) && (cnt_q == TMO_LAST);
    assign force_done = tmo_fire ? (arm & ~complete & ~hit) : '0;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            tmo_q <= '0;
        end else if (start_acc) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q | force_done;
        end
    end
    assign bus.TIMEOUT_MASK = tmo_q;
`else
    assign tmo_fire         = 1'b0;
    assign force_done       = '0;
    assign bus.TIMEOUT_MASK = '0;
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cur_q   <= '0;
            mode_q  <= MODE_SEQ;
            en_q    <= '0;
            init_q  <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            pass_q <= pass_q | (hit & ~err_hit);
            fail_q <= fail_q | err_hit;
            unique case (state_q)
                StIdle: begin
                    if (bus.START) begin
                        mode_q <= bus.MODE;
                        en_q   <= bus.CH_ENABLE;
                        pass_q <= '0;
                        fail_q <= '0;
                        cnt_q  <= '0;
                        if (bus.CH_ENABLE == '0) begin
                            state_q <= StFinish;
                            done_q  <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            cur_q   <= first_ch[IW-1:0];
                            state_q <= LAUNCH_ST;
                            if (GAP_CYCLES == 0) begin
                                init_q <= (bus.MODE == MODE_CONC) ? bus.CH_ENABLE
                                                                  : onehot(first_ch[IW-1:0]);
                            end
                        end
                    end
                end
                StGap: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= StPulse;
                        init_q  <= (mode_q == MODE_CONC) ? en_q : onehot(cur_q);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StPulse, StWait: begin
                    logic leave;
                    if (state_q == StPulse) begin
                        leave = (cnt_q == PULSE_LAST) &&
                                ((mode_q == MODE_CONC) ? all_done : cur_done);
                        if (cnt_q == PULSE_LAST) begin
                            init_q <= '0;
                            cnt_q  <= '0;
                            if (!leave) state_q <= StWait;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        leave = tmo_fire ||
                                ((mode_q == MODE_CONC) ? all_done : hit[cur_q]);
`ifdef UW_SEQ_TIMEOUT_EN
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                    if (leave) begin
                        cnt_q <= '0;
                        if (mode_q == MODE_SEQ && next_ch[IW]) begin
                            cur_q   <= next_ch[IW-1:0];
                            state_q <= LAUNCH_ST;
                            if (GAP_CYCLES == 0) init_q <= onehot(next_ch[IW-1:0]);
                        end else begin
                            state_q <= StFinish;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                StFinish: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    assign bus.INIT_AXI_TXN = init_q;
    assign bus.BUSY         = busy_q;
    assign bus.DONE         = done_q;
    assign bus.PASS_MASK    = pass_q;
    assign bus.FAIL_MASK    = fail_q;
endmodule

// File: tb/tb_uw_channel_sequencer.sv
// Directed bench for uw_channel_sequencer with a behavioural wrapper responder.
module tb_uw_channel_sequencer;
    import uw_seq_pkg::*;

    localparam int unsigned NUM_CH = 8;

    logic ACLK    = 1'b0;
    logic ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    uw_channel_sequencer_if #(.NUM_CH(NUM_CH)) bus ();

    uw_channel_sequencer #(
        .NUM_CH         (NUM_CH),
        .GAP_CYCLES     (20),
        .PULSE_LEN      (2),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wrapper model: done drops when init rises, rises delay_cfg cycles later.
    logic [NUM_CH-1:0] resp_done = '0;
    logic [NUM_CH-1:0] resp_err  = '0;
    logic [NUM_CH-1:0] resp_en;
    logic [NUM_CH-1:0] err_cfg;
    logic [NUM_CH-1:0] stale_done;
    logic [NUM_CH-1:0] rp_prev   = '0;
    int                delay_cfg [NUM_CH];
    int                cd        [NUM_CH];

    assign bus.TXN_DONE = resp_done | stale_done;
    assign bus.ERROR    = resp_err;

    initial for (int g = 0; g < NUM_CH; g++) cd[g] = 0;

    always @(negedge ACLK) begin
        for (int g = 0; g < NUM_CH; g++) begin
            if (bus.INIT_AXI_TXN[g] && !rp_prev[g]) begin
                resp_done[g] <= 1'b0;
                cd[g]        <= resp_en[g] ? delay_cfg[g] : 0;
            end else if (cd[g] > 0) begin
                cd[g] <= cd[g] - 1;
                if (cd[g] == 1) begin
                    resp_done[g] <= 1'b1;
                    resp_err[g]  <= err_cfg[g];
                end
            end
        end
        rp_prev <= bus.INIT_AXI_TXN;
    end

    // Monitor of INIT pulses and DONE.
    logic [NUM_CH-1:0] mon_prev = '0;
    int                run_len  = 0;
    int                done_cnt = 0;
    int                rise_q [$];
    logic [NUM_CH-1:0] pat_q  [$];
    int                wid_q  [$];

    always @(negedge ACLK) begin
        if (bus.INIT_AXI_TXN != '0 && mon_prev == '0) begin
            rise_q.push_back(cyc);
            pat_q.push_back(bus.INIT_AXI_TXN);
        end
        if (bus.INIT_AXI_TXN == '0 && mon_prev != '0) wid_q.push_back(run_len);
        run_len  <= (bus.INIT_AXI_TXN != '0) ? run_len + 1 : 0;
        if (bus.DONE) done_cnt <= done_cnt + 1;
        mon_prev <= bus.INIT_AXI_TXN;
    end

    task automatic run_start(input logic mode, input logic [NUM_CH-1:0] en, output int s);
        @(negedge ACLK);
        bus.START     = 1'b1;
        bus.MODE      = mode;
        bus.CH_ENABLE = en;
        s             = cyc;
        @(negedge ACLK);
        bus.START     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int d, output logic ok);
        ok = 1'b0;
        d  = -1;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge ACLK);
            if (bus.DONE) begin
                ok = 1'b1;
                d  = cyc;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   s, d, br, bw, dc, k;
        logic ok;
        bus.START     = 1'b0;
        bus.MODE      = MODE_SEQ;
        bus.CH_ENABLE = '0;
        stale_done    = '0;
        resp_en       = '1;
        err_cfg       = '0;
        for (int g = 0; g < NUM_CH; g++) delay_cfg[g] = 50;

        // Reset state
        repeat (3) @(negedge ACLK);
        check_eq("rst_init", bus.INIT_AXI_TXN, 0);
        check_eq("rst_busy", bus.BUSY, 0);
        check_eq("rst_done", bus.DONE, 0);
        check_eq("rst_pass", bus.PASS_MASK, 0);
        check_eq("rst_fail", bus.FAIL_MASK, 0);
        check_eq("rst_tmo", bus.TIMEOUT_MASK, 0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        // Sequential, all channels, done 50 cycles after each pulse
        br = rise_q.size(); bw = wid_q.size(); dc = done_cnt;
        run_start(MODE_SEQ, 8'hFF, s);
        check_eq("t1_busy", bus.BUSY, 1);
        wait_done(2000, d, ok);
        check_eq("t1_done_seen", ok, 1);
        check_eq("t1_done_cyc", d, s + 569);
        check_eq("t1_busy_at_done", bus.BUSY, 0);
        check_eq("t1_pass", bus.PASS_MASK, 8'hFF);
        check_eq("t1_fail", bus.FAIL_MASK, 8'h00);
        check_eq("t1_tmo", bus.TIMEOUT_MASK, 8'h00);
        repeat (3) @(negedge ACLK);
        check_eq("t1_npulse", rise_q.size() - br, 8);
        check_eq("t1_ndone", done_cnt - dc, 1);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t1_pat%0d", i), pat_q[br + i], 64'(1) << i);
            check_eq($sformatf("t1_rise%0d", i), rise_q[br + i], s + 21 + 71 * i);
            check_eq($sformatf("t1_wid%0d", i), wid_q[bw + i], 2);
        end

        // Sequential, sparse enable, with an ignored START mid-run
        br = rise_q.size(); dc = done_cnt;
        run_start(MODE_SEQ, 8'b1010_0101, s);
        repeat (30) @(negedge ACLK);
        bus.START = 1'b1; bus.MODE = MODE_CONC; bus.CH_ENABLE = 8'hFF;
        @(negedge ACLK);
        bus.START = 1'b0;
        wait_done(2000, d, ok);
        check_eq("t2_done_cyc", d, s + 285);
        check_eq("t2_pass", bus.PASS_MASK, 8'hA5);
        check_eq("t2_fail", bus.FAIL_MASK, 8'h00);
        repeat (3) @(negedge ACLK);
        check_eq("t2_npulse", rise_q.size() - br, 4);
        check_eq("t2_ndone", done_cnt - dc, 1);
        check_eq("t2_pat0", pat_q[br + 0], 8'h01);
        check_eq("t2_pat1", pat_q[br + 1], 8'h04);
        check_eq("t2_pat2", pat_q[br + 2], 8'h20);
        check_eq("t2_pat3", pat_q[br + 3], 8'h80);
        check_eq("t2_rise3", rise_q[br + 3], s + 234);

        // Concurrent, reverse-order completions, channel 3 errors
        for (int g = 0; g < NUM_CH; g++) delay_cfg[g] = 10 + 5 * (7 - g);
        err_cfg = 8'h08;
        br = rise_q.size(); bw = wid_q.size();
        run_start(MODE_CONC, 8'hFF, s);
        wait_done(500, d, ok);
        check_eq("t3_done_cyc", d, s + 67);
        check_eq("t3_pass", bus.PASS_MASK, 8'hF7);
        check_eq("t3_fail", bus.FAIL_MASK, 8'h08);
        repeat (3) @(negedge ACLK);
        check_eq("t3_npulse", rise_q.size() - br, 1);
        check_eq("t3_pat", pat_q[br], 8'hFF);
        check_eq("t3_rise", rise_q[br], s + 21);
        check_eq("t3_wid", wid_q[bw], 2);
        err_cfg = '0;
        for (int g = 0; g < NUM_CH; g++) delay_cfg[g] = 50;

        // Stale TXN_DONE[0] held high across START
        resp_en[0]    = 1'b0;
        stale_done[0] = 1'b1;
        repeat (2) @(negedge ACLK);
        dc = done_cnt;
        run_start(MODE_SEQ, 8'h01, s);
        repeat (100) @(negedge ACLK);
        check_eq("t4_still_busy", bus.BUSY, 1);
        check_eq("t4_no_done", done_cnt - dc, 0);
        check_eq("t4_no_pass", bus.PASS_MASK, 0);
        stale_done[0] = 1'b0;
        repeat (2) @(negedge ACLK);
        stale_done[0] = 1'b1;
        k = cyc;
        wait_done(50, d, ok);
        check_eq("t4_done_cyc", d, k + 1);
        check_eq("t4_pass", bus.PASS_MASK, 8'h01);
        stale_done = '0;
        resp_en    = '1;

        // Zero enable: DONE right after START, masks cleared
        run_start(MODE_SEQ, 8'h00, s);
        check_eq("t5_done", bus.DONE, 1);
        check_eq("t5_busy", bus.BUSY, 0);
        check_eq("t5_pass", bus.PASS_MASK, 0);
        check_eq("t5_fail", bus.FAIL_MASK, 0);
        @(negedge ACLK);
        check_eq("t5_done_once", bus.DONE, 0);

        // Reset during PULSE
        run_start(MODE_SEQ, 8'h01, s);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge ACLK);
            ok = (bus.INIT_AXI_TXN != '0);
        end
        check_eq("t6_pulse_seen", ok, 1);
        check_eq("t6_pulse_cyc", cyc, s + 21);
        ARESETN = 1'b0;
        @(negedge ACLK);
        check_eq("t6_init_rst", bus.INIT_AXI_TXN, 0);
        check_eq("t6_busy_rst", bus.BUSY, 0);
        ARESETN = 1'b1;
        repeat (3) @(negedge ACLK);
        check_eq("t6_idle_init", bus.INIT_AXI_TXN, 0);

`ifdef UW_SEQ_TIMEOUT_EN
        // Channel 1 never completes: watchdog after 100 WAIT cycles
        resp_en[1] = 1'b0;
        run_start(MODE_SEQ, 8'h06, s);
        wait_done(1000, d, ok);
        check_eq("t7_done_cyc", d, s + 194);
        check_eq("t7_tmo", bus.TIMEOUT_MASK, 8'h02);
        check_eq("t7_pass", bus.PASS_MASK, 8'h04);
        check_eq("t7_fail", bus.FAIL_MASK, 8'h00);
        resp_en = '1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uw_channel_sequencer.md
# uw_channel_sequencer

Parametrised launch-and-collect controller for the Unet_Wrapper AXI master channels. It drives each channel's INIT_AXI_TXN pulse, waits for that channel's TXN_DONE, and records ERROR into per-channel pass, fail and timeout masks. Channels run either one after another or all at once. It sits beside the Unet_Wrapper in the block design and replaces hand-sequenced init strobes with an on-chip sequencer that supports any channel count.

## Interface
Parameters:
- NUM_CH, 8, number of wrapper channels (1..32)
- GAP_CYCLES, 20, idle cycles before each init pulse (0 allowed)
- PULSE_LEN, 2, init pulse width in cycles (must be ≥1)
- TIMEOUT_CYCLES, 65535, WAIT-cycle watchdog limit (used only with UW_SEQ_TIMEOUT_EN)

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESETN  in  1  synchronous, active-low reset
- START  in  1  launch request, accepted only in IDLE
- MODE  in  1  0 = sequential, 1 = concurrent; latched at START
- CH_ENABLE  in  NUM_CH  channels to run; latched at START
- INIT_AXI_TXN  out  NUM_CH  per-channel init pulse to the wrapper
- TXN_DONE  in  NUM_CH  per-channel done level from the wrapper
- ERROR  in  NUM_CH  per-channel error level from the wrapper
- BUSY  out  1  high from START acceptance until DONE
- DONE  out  1  one-cycle completion pulse
- PASS_MASK / FAIL_MASK / TIMEOUT_MASK  out  NUM_CH  result masks, valid from DONE until the next START

## Operation
- States: IDLE, GAP, PULSE, WAIT, FINISH.
- Completion is a rising edge of TXN_DONE[i], detected against a registered copy of TXN_DONE. Edge detection is armed from the first PULSE cycle, so a stale high level from a previous run never counts.
- ERROR[i] is sampled on the same cycle as the completion edge:
  - ERROR[i]=1 sets FAIL_MASK[i]; otherwise PASS_MASK[i] is set.
  - Each channel is recorded at most once per run.
- IDLE:
  - START=1 latches MODE and CH_ENABLE, clears all three masks and sets BUSY.
  - If the latched CH_ENABLE is zero, go to FINISH; otherwise go to GAP.
- Sequential mode (MODE=0):
  - Channels are visited in ascending index order; disabled channels are skipped with no cycles spent on them.
  - Per channel: GAP, then PULSE (INIT_AXI_TXN[cur]=1), then WAIT.
  - On the completion edge, move to the next enabled channel's GAP, or to FINISH after the last one.
- Concurrent mode (MODE=1):
  - One GAP, then one PULSE on all enabled channels together.
  - WAIT until every enabled channel has completed, then go to FINISH.
- GAP_CYCLES=0: GAP is skipped and PULSE follows directly.
- FINISH: DONE=1 for exactly one cycle, BUSY drops in the same cycle, then return to IDLE.
- START while BUSY is ignored; it is not queued.
- Inputs on disabled channels are ignored and their mask bits stay 0.
- Reset values (ARESETN=0 at a rising edge): state IDLE; INIT_AXI_TXN, BUSY, DONE and all masks are 0; counters and edge registers are 0. Reset mid-run drops any INIT pulse at that edge and discards partial results.

## Timing
- START sampled at edge t: BUSY=1 and the state is GAP from t+1.
- First INIT_AXI_TXN rises at t+1+GAP_CYCLES and stays high for exactly PULSE_LEN cycles.
- Completion edge seen at cycle c:
  - Sequential, more channels left: next GAP starts at c+1.
  - Otherwise FINISH at c+1, i.e. DONE at c+1.
- Zero CH_ENABLE: DONE is pulsed at t+1.
- A completion edge arriving during PULSE is recorded. In sequential mode the controller still completes PULSE_LEN, then skips WAIT.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- UW_SEQ_TIMEOUT_EN defined:
  - A WAIT-cycle counter runs per channel in sequential mode, or over the whole WAIT in concurrent mode.
  - When the count reaches TIMEOUT_CYCLES, every enabled, still-incomplete channel gets TIMEOUT_MASK=1 (not PASS, not FAIL). Sequencing then proceeds as if those channels had completed.
- UW_SEQ_TIMEOUT_EN undefined: WAIT lasts indefinitely, TIMEOUT_MASK is tied to 0, and the counter is not built.

## Structure
- Package uw_seq_pkg holds:
  - the state enum typedef;
  - MODE_SEQ/MODE_CONC constants;
  - a localparam function for counter width, $clog2 of the maximum of GAP_CYCLES, PULSE_LEN and TIMEOUT_CYCLES.
- Sub-module uw_seq_ch_tracker, instantiated NUM_CH times via generate. Each instance holds:
  - the TXN_DONE edge detect with its arm input;
  - the sticky complete flag;
  - the captured error bit.
- The top level holds the FSM, the shared counter, the current-channel index and the mask registers.

## Test plan
- Sequential, CH_ENABLE=8'hFF, all ERROR=0, each done returned 50 cycles after its pulse -> 8 pulses each 2 cycles wide with 20 idle cycles before each; PASS_MASK=8'hFF, FAIL_MASK=0; DONE pulses once.
- Sequential, CH_ENABLE=8'b1010_0101 -> pulses only on channels 0, 2, 5, 7, in that order; the other mask bits stay 0.
- Concurrent, CH_ENABLE=8'hFF, done edges in reverse order, ERROR[3]=1 at its edge -> a single simultaneous pulse; DONE one cycle after the last edge; FAIL_MASK=8'h08, PASS_MASK=8'hF7.
- Stale TXN_DONE[0] held high from before START, channel 0 enabled -> no completion until a fresh low-to-high edge arrives.
- START=1 with CH_ENABLE=0 -> DONE at t+1, masks 0; a START pulsed mid-run -> ignored, INIT pattern unchanged.
- With UW_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, channel 1 never done -> TIMEOUT_MASK=8'h02 and channel 2 proceeds. Separately, ARESETN=0 during PULSE -> INIT_AXI_TXN=0 and BUSY=0 at the next edge.
